// File: rtl/nec_ir_rx.sv
// NEC infrared frame decoder: measures mark/space lengths in T/8 ticks and
// reports address/command, repeat codes and malformed frames as 1-cycle strobes.
module nec_ir_rx #(
  parameter int TICK_DIV = 703
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       ir_in,
  output logic [7:0] addr,
  output logic [7:0] cmd,
  output logic       valid,
  output logic       rpt,
  output logic       err,
  output logic       busy
);

  localparam int PRE_W = (TICK_DIV > 2) ? $clog2(TICK_DIV) : 1;
  localparam logic [PRE_W-1:0] PRE_LAST = PRE_W'(TICK_DIV - 1);

  typedef enum logic [2:0] {
    IDLE, LEAD_MARK, LEAD_SPACE, BIT_MARK, BIT_SPACE, STOP_MARK, RPT_MARK
  } state_t;

  logic             sync1_q, sync2_q, mark_q;
  logic [PRE_W-1:0] pre_q, pre_d;
  logic [7:0]       dur_q, dur_d, dur_inc;
  state_t           state_q, state_d;
  logic [31:0]      sr_q, sr_d;
  logic [5:0]       bit_cnt_q, bit_cnt_d;
  logic             have_q, have_d;
  logic [7:0]       addr_q, addr_d, cmd_q, cmd_d;
  logic             valid_q, valid_d, rpt_q, rpt_d, err_q, err_d, busy_q, busy_d;
  logic             mark, edge_det, tick, timeout;

  function automatic logic in_win(input logic [7:0] d, input logic [7:0] lo,
                                  input logic [7:0] hi);
    return (d >= lo) && (d <= hi);
  endfunction

  assign mark     = ~sync2_q;
  assign edge_det = mark ^ mark_q;
  assign tick     = (pre_q == PRE_LAST);

  // dur_inc includes the tick landing on this cycle, so an N-tick segment is judged as N.
  always_comb begin
    pre_d   = (edge_det || tick) ? '0 : pre_q + PRE_W'(1);
    dur_inc = (tick && dur_q != 8'hFF) ? dur_q + 8'd1 : dur_q;
    dur_d   = edge_det ? 8'd0 : dur_inc;
    timeout = !edge_det && tick && (dur_q == 8'd254);
  end

  always_comb begin
    state_d   = state_q;
    sr_d      = sr_q;
    bit_cnt_d = bit_cnt_q;
    have_d    = have_q;
    addr_d    = addr_q;
    cmd_d     = cmd_q;
    valid_d   = 1'b0;
    rpt_d     = 1'b0;
    err_d     = 1'b0;
    if (edge_det) begin
      case (state_q)
        IDLE: if (mark) state_d = LEAD_MARK;
        LEAD_MARK: begin
          if (in_win(dur_inc, 8'd112, 8'd144)) state_d = LEAD_SPACE;
          else begin err_d = 1'b1; state_d = IDLE; end
        end
        LEAD_SPACE: begin
          if (in_win(dur_inc, 8'd56, 8'd72)) begin
            state_d   = BIT_MARK;
            bit_cnt_d = 6'd0;
          end else if (in_win(dur_inc, 8'd24, 8'd40)) state_d = RPT_MARK;
          else begin err_d = 1'b1; state_d = IDLE; end
        end
        BIT_MARK: begin
          if (in_win(dur_inc, 8'd4, 8'd12)) state_d = BIT_SPACE;
          else begin err_d = 1'b1; state_d = IDLE; end
        end
        BIT_SPACE: begin
          if (in_win(dur_inc, 8'd4, 8'd12) || in_win(dur_inc, 8'd18, 8'd30)) begin
            // Bits arrive LSB first: each new bit enters at the top and walks down.
            sr_d      = {in_win(dur_inc, 8'd18, 8'd30), sr_q[31:1]};
            bit_cnt_d = bit_cnt_q + 6'd1;
            state_d   = (bit_cnt_q == 6'd31) ? STOP_MARK : BIT_MARK;
          end else begin err_d = 1'b1; state_d = IDLE; end
        end
        STOP_MARK: begin
          state_d = IDLE;
          if (in_win(dur_inc, 8'd4, 8'd12) && (sr_q[15:8] == ~sr_q[7:0]) &&
              (sr_q[31:24] == ~sr_q[23:16])) begin
            addr_d  = sr_q[7:0];
            cmd_d   = sr_q[23:16];
            valid_d = 1'b1;
            have_d  = 1'b1;
          end else err_d = 1'b1;
        end
        RPT_MARK: begin
          state_d = IDLE;
          if (in_win(dur_inc, 8'd4, 8'd12)) rpt_d = have_q;
          else err_d = 1'b1;
        end
        default: state_d = IDLE;
      endcase
    end else if (timeout && state_q != IDLE) begin
      err_d   = 1'b1;
      state_d = IDLE;
    end
    busy_d = (state_d != IDLE);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sync1_q   <= 1'b1;
      sync2_q   <= 1'b1;
      mark_q    <= 1'b0;
      pre_q     <= '0;
      dur_q     <= 8'd0;
      state_q   <= IDLE;
      sr_q      <= 32'd0;
      bit_cnt_q <= 6'd0;
      have_q    <= 1'b0;
      addr_q    <= 8'd0;
      cmd_q     <= 8'd0;
      valid_q   <= 1'b0;
      rpt_q     <= 1'b0;
      err_q     <= 1'b0;
      busy_q    <= 1'b0;
    end else begin
      sync1_q   <= ir_in;
      sync2_q   <= sync1_q;
      mark_q    <= mark;
      pre_q     <= pre_d;
      dur_q     <= dur_d;
      state_q   <= state_d;
      sr_q      <= sr_d;
      bit_cnt_q <= bit_cnt_d;
      have_q    <= have_d;
      addr_q    <= addr_d;
      cmd_q     <= cmd_d;
      valid_q   <= valid_d;
      rpt_q     <= rpt_d;
      err_q     <= err_d;
      busy_q    <= busy_d;
    end
  end

  assign addr  = addr_q;
  assign cmd   = cmd_q;
  assign valid = valid_q;
  assign rpt   = rpt_q;
  assign err   = err_q;
  assign busy  = busy_q;

endmodule

// File: tb/tb_nec_ir_rx.sv
// Bench for nec_ir_rx: IR waveforms are lists of mark/space tick counts, decoded
// by a segment-level protocol model and compared with the strobes the DUT emits.
module tb_nec_ir_rx;
  localparam int TD     = 4;
  localparam int IDLE_T = 262;

  logic       clk = 1'b0;
  logic       rst, ir_in;
  logic [7:0] addr, cmd;
  logic       valid, rpt, err, busy;

  nec_ir_rx #(.TICK_DIV(TD)) dut (
    .clk(clk), .rst(rst), .ir_in(ir_in), .addr(addr), .cmd(cmd),
    .valid(valid), .rpt(rpt), .err(err), .busy(busy)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int checks = 0;
  int errors = 0;

  logic [17:0] exp_q[$];
  logic [17:0] obs_q[$];
  int          obs_cyc_q[$];
  int          seg_q[$];
  int          last_rise;
  logic        m_have;
  logic [7:0]  m_addr, m_cmd;

  typedef struct {
    logic        is_rpt;
    logic [7:0]  a, na, c, nc;
    int          lm, ls, em, nbits, bad_bit, bad_sp;
    logic [17:0] exp_first;
  } vec_t;
  vec_t tbl[11];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Strobe monitor: records kind (1 valid, 2 rpt, 3 err) with addr/cmd and cycle.
  always @(negedge clk) begin
    if (!rst && (valid || rpt || err)) begin
      check("strobe_onehot", 32'(valid) + 32'(rpt) + 32'(err), 32'd1);
      obs_q.push_back({valid ? 2'd1 : (rpt ? 2'd2 : 2'd3), addr, cmd});
      obs_cyc_q.push_back(cyc);
    end
  end

  // ---------------- reference model over tick-count segments ----------------
  function automatic bit inw(input int d, input int lo, input int hi);
    return (d >= lo) && (d <= hi);
  endfunction

  // Where decoding resumes after a rejected segment k. A space that timed out
  // leaves its closing rise free to start a frame; a rejected rise is consumed.
  function automatic int after_err(input int k, input int d);
    if (k % 2 == 0) return k + 2;
    return (d > 255) ? k + 1 : k + 3;
  endfunction

  task automatic model_err();
    exp_q.push_back({2'd3, m_addr, m_cmd});
  endtask

  task automatic model_run();
    int n, i, k;
    int unsigned word, ba, bna, bc, bnc;
    bit bad;
    n = seg_q.size();
    i = 0;
    while (i < n) begin
      k = i;
      if (!inw(seg_q[k], 112, 144)) begin model_err(); i = after_err(k, seg_q[k]); continue; end
      k++;
      if (k >= n) break;
      if (inw(seg_q[k], 24, 40)) begin
        k++;
        if (k >= n) break;
        if (inw(seg_q[k], 4, 12)) begin
          if (m_have) exp_q.push_back({2'd2, m_addr, m_cmd});
          i = k + 2;
        end else begin
          model_err(); i = after_err(k, seg_q[k]);
        end
        continue;
      end
      if (!inw(seg_q[k], 56, 72)) begin model_err(); i = after_err(k, seg_q[k]); continue; end
      word = 0;
      bad  = 0;
      for (int b = 0; b < 32 && !bad; b++) begin
        k++;
        if (k >= n || !inw(seg_q[k], 4, 12)) bad = 1;
        else begin
          k++;
          if (k >= n) bad = 1;
          else if (inw(seg_q[k], 18, 30)) word += (32'd1 << b);
          else if (!inw(seg_q[k], 4, 12)) bad = 1;
        end
      end
      if (!bad) begin
        k++;
        if (k >= n || !inw(seg_q[k], 4, 12)) bad = 1;
      end
      if (bad) begin
        if (k >= n) break;
        model_err(); i = after_err(k, seg_q[k]);
        continue;
      end
      ba  = word % 256;
      bna = (word / 256) % 256;
      bc  = (word / 65536) % 256;
      bnc = word / 16777216;
      if (ba + bna == 255 && bc + bnc == 255) begin
        m_addr = 8'(ba);
        m_cmd  = 8'(bc);
        m_have = 1'b1;
        exp_q.push_back({2'd1, m_addr, m_cmd});
      end else model_err();
      i = k + 2;
    end
  endtask

  // ---------------- stimulus builders and driver ----------------
  task automatic build_frame(input logic [7:0] a, na, c, nc, input int lm, ls, nbits,
                             bad_bit, bad_sp);
    logic [31:0] word;
    word = {nc, c, na, a};
    seg_q.delete();
    seg_q.push_back(lm);
    seg_q.push_back(ls);
    for (int b = 0; b < nbits; b++) begin
      seg_q.push_back(8);
      seg_q.push_back((b == bad_bit) ? bad_sp : (word[b] ? 24 : 8));
    end
    seg_q.push_back(8);
    seg_q.push_back(IDLE_T);
  endtask

  task automatic build_repeat(input int lm, ls, em);
    seg_q.delete();
    seg_q.push_back(lm);
    seg_q.push_back(ls);
    seg_q.push_back(em);
    seg_q.push_back(IDLE_T);
  endtask

  task automatic build_random();
    int mode, p;
    logic [7:0]  a, c;
    logic [31:0] word;
    mode = int'($urandom_range(0, 3));
    a = 8'($urandom);
    c = 8'($urandom);
    seg_q.delete();
    if (mode == 2) begin
      build_repeat(int'($urandom_range(112, 144)), int'($urandom_range(24, 40)),
                   int'($urandom_range(4, 12)));
      return;
    end
    word = (mode == 1) ? $urandom : {~c, c, ~a, a};
    seg_q.push_back(int'($urandom_range(112, 144)));
    seg_q.push_back(int'($urandom_range(56, 72)));
    for (int b = 0; b < 32; b++) begin
      seg_q.push_back(int'($urandom_range(4, 12)));
      seg_q.push_back(word[b] ? int'($urandom_range(18, 30)) : int'($urandom_range(4, 12)));
    end
    seg_q.push_back(int'($urandom_range(4, 12)));
    seg_q.push_back(IDLE_T);
    if (mode == 3) begin
      p = int'($urandom_range(0, seg_q.size() - 2));
      seg_q[p] = int'($urandom_range(1, 40));
    end
  endtask

  task automatic drive_segs(input int count);
    for (int j = 0; j < count; j++) begin
      if (j % 2 == 0) ir_in = 1'b0;
      else begin
        ir_in = 1'b1;
        last_rise = cyc;
      end
      repeat (seg_q[j] * TD) @(negedge clk);
    end
  endtask

  task automatic run_seq(input string name);
    exp_q.delete();
    obs_q.delete();
    obs_cyc_q.delete();
    model_run();
    drive_segs(seg_q.size());
    check({name, "_count"}, 32'(obs_q.size()), 32'(exp_q.size()));
    for (int j = 0; j < exp_q.size() && j < obs_q.size(); j++)
      check($sformatf("%s_ev%0d", name, j), 32'(obs_q[j]), 32'(exp_q[j]));
    check({name, "_busy_end"}, 32'(busy), 32'd0);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish, got timeout expected finish");
    $fatal(1);
  end

  initial begin
    int waited, t0;
    tbl[0]  = '{1'b1, 8'h00, 8'h00, 8'h00, 8'h00, 128, 32, 8,  0, -1, 0, {2'd2, 8'h04, 8'h08}};
    tbl[1]  = '{1'b0, 8'h04, 8'hFB, 8'h08, 8'hF6, 128, 64, 0, 32, -1, 0, {2'd3, 8'h04, 8'h08}};
    tbl[2]  = '{1'b0, 8'h04, 8'hFB, 8'h08, 8'hF7, 111, 64, 0,  8, -1, 0, {2'd3, 8'h04, 8'h08}};
    tbl[3]  = '{1'b0, 8'h12, 8'hED, 8'h34, 8'hCB, 112, 64, 0, 32, -1, 0, {2'd1, 8'h12, 8'h34}};
    tbl[4]  = '{1'b0, 8'h04, 8'hFB, 8'h08, 8'hF7, 144, 64, 0, 32, -1, 0, {2'd1, 8'h04, 8'h08}};
    tbl[5]  = '{1'b0, 8'h04, 8'hFB, 8'h08, 8'hF7, 145, 64, 0,  8, -1, 0, {2'd3, 8'h04, 8'h08}};
    tbl[6]  = '{1'b0, 8'h04, 8'hFB, 8'h08, 8'hF7, 128, 64, 0,  8,  5, 31, {2'd3, 8'h04, 8'h08}};
    tbl[7]  = '{1'b1, 8'h00, 8'h00, 8'h00, 8'h00, 128, 24, 8,  0, -1, 0, {2'd2, 8'h04, 8'h08}};
    tbl[8]  = '{1'b1, 8'h00, 8'h00, 8'h00, 8'h00, 128, 41, 8,  0, -1, 0, {2'd3, 8'h04, 8'h08}};
    tbl[9]  = '{1'b0, 8'hA5, 8'h5A, 8'h3C, 8'hC3, 128, 72, 0, 32, -1, 0, {2'd1, 8'hA5, 8'h3C}};
    tbl[10] = '{1'b0, 8'h01, 8'hFE, 8'h80, 8'h7F, 128, 56, 0, 32,  0, 30, {2'd1, 8'h01, 8'h80}};

    // clock/reset
    rst = 1'b1;
    ir_in = 1'b1;
    m_have = 1'b0;
    m_addr = 8'h00;
    m_cmd = 8'h00;
    repeat (3) @(negedge clk);
    check("rst_addr", 32'(addr), 32'h0);
    check("rst_cmd", 32'(cmd), 32'h0);
    check("rst_valid", 32'(valid), 32'h0);
    check("rst_rpt", 32'(rpt), 32'h0);
    check("rst_err", 32'(err), 32'h0);
    check("rst_busy", 32'(busy), 32'h0);
    rst = 1'b0;
    repeat (20) @(negedge clk);

    // repeat code with no earlier frame: silence
    build_repeat(128, 32, 8);
    run_seq("rpt_after_reset");
    check("rpt_after_reset_silent", 32'(obs_q.size()), 32'd0);

    // nominal frame 04/08 and its strobe latency
    build_frame(8'h04, 8'hFB, 8'h08, 8'hF7, 128, 64, 32, -1, 0);
    run_seq("nominal");
    check("nominal_latency", (obs_cyc_q.size() > 0) ? 32'(obs_cyc_q[0] - last_rise) : 32'hFFFF, 32'd3);
    check("nominal_addr", 32'(addr), 32'h04);
    check("nominal_cmd", 32'(cmd), 32'h08);

    // table-driven vectors
    for (int i = 0; i < 11; i++) begin
      if (tbl[i].is_rpt) build_repeat(tbl[i].lm, tbl[i].ls, tbl[i].em);
      else build_frame(tbl[i].a, tbl[i].na, tbl[i].c, tbl[i].nc, tbl[i].lm, tbl[i].ls,
                       tbl[i].nbits, tbl[i].bad_bit, tbl[i].bad_sp);
      run_seq($sformatf("vec%0d", i));
      check($sformatf("vec%0d_first", i),
            (obs_q.size() > 0) ? 32'(obs_q[0]) : 32'hFFFFF, 32'(tbl[i].exp_first));
    end

    // randomized frames against the model
    for (int i = 0; i < 4; i++) begin
      build_random();
      run_seq($sformatf("rand%0d", i));
    end

    // stuck-low input: timeout at 255 ticks
    obs_q.delete();
    obs_cyc_q.delete();
    ir_in = 1'b0;
    t0 = cyc;
    waited = 0;
    while (!err && waited < 2000) begin
      @(negedge clk);
      waited++;
      if (waited == 40) check("timeout_busy_during", 32'(busy), 32'd1);
    end
    check("timeout_latency", 32'(cyc - t0), 32'(3 + 255 * TD));
    check("timeout_busy_after", 32'(busy), 32'd0);
    ir_in = 1'b1;
    repeat (20 * TD) @(negedge clk);
    check("timeout_single_err", 32'(obs_q.size()), 32'd1);

    // async reset during bit 17
    obs_q.delete();
    build_frame(8'h33, 8'hCC, 8'h0F, 8'hF0, 128, 64, 32, -1, 0);
    drive_segs(34);
    ir_in = 1'b0;
    repeat (2 * TD) @(negedge clk);
    #1;
    rst = 1'b1;
    ir_in = 1'b1;
    #1;
    check("rstmid_addr", 32'(addr), 32'h0);
    check("rstmid_cmd", 32'(cmd), 32'h0);
    check("rstmid_valid", 32'(valid), 32'h0);
    check("rstmid_rpt", 32'(rpt), 32'h0);
    check("rstmid_err", 32'(err), 32'h0);
    check("rstmid_busy", 32'(busy), 32'h0);
    check("rstmid_no_strobe", 32'(obs_q.size()), 32'd0);
    m_have = 1'b0;
    m_addr = 8'h00;
    m_cmd = 8'h00;
    repeat (3) @(negedge clk);
    rst = 1'b0;
    repeat (20) @(negedge clk);
    build_repeat(128, 32, 8);
    run_seq("rstmid_rpt");
    build_frame(8'h55, 8'hAA, 8'hAA, 8'h55, 128, 64, 32, -1, 0);
    run_seq("rstmid_frame");
    check("rstmid_frame_first", (obs_q.size() > 0) ? 32'(obs_q[0]) : 32'hFFFFF,
          32'({2'd1, 8'h55, 8'hAA}));
    check("rstmid_frame_addr", 32'(addr), 32'h55);
    check("rstmid_frame_cmd", 32'(cmd), 32'hAA);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule

// File: doc/nec_ir_rx.md
Name: nec_ir_rx

Overview:
- NEC-protocol infrared receiver/decoder for the TV-B-Gone tile; receive-side counterpart of the IR LED transmit path.
- Takes the demodulated, active-low output of an external 38 kHz IR receiver module and measures mark/space durations in prescaled ticks.
- Decodes 32-bit NEC frames and repeat codes, and reports address/command with one-cycle strobes.
- Used for learning codes and for loopback self-test of the transmitter.

Parameters:
- TICK_DIV, 703, clk cycles per tick; tick = T/8, T = 562.5 us (703 at 10 MHz). Minimum 2.

Ports:
- clk  input  1  system clock
- rst  input  1  asynchronous, active-high reset
- ir_in  input  1  raw receiver output; low = carrier present (mark), idle high
- addr  output  8  address of last valid frame
- cmd  output  8  command of last valid frame
- valid  output  1  one-cycle strobe: new frame decoded; addr/cmd updated the same cycle
- rpt  output  1  one-cycle strobe: repeat code received after an earlier valid frame
- err  output  1  one-cycle strobe: malformed or timed-out frame
- busy  output  1  high whenever the FSM is not in IDLE

Behaviour:
- Reset values:
  - sync FFs = 1; addr = cmd = 0; valid = rpt = err = busy = 0.
  - FSM = IDLE; have_frame = 0; shift register = 0; bit count = 0.
- Input conditioning:
  - 2-FF synchronizer; mark = ~ir_sync.
  - Edge = mark differs from its registered copy.
- Prescaler: 0..TICK_DIV-1; emits tick on terminal count; cleared on every edge.
- Duration counter dur:
  - 8 bits; +1 per tick; saturates at 255; cleared to 0 on every edge.
  - Each segment is judged by dur at the edge that ends it.
- FSM. Windows are inclusive tick ranges; any edge outside its window -> err, go to IDLE.
  - IDLE: mark rising -> LEAD_MARK.
  - LEAD_MARK (9 ms nominal, 128 ticks): mark falls with dur in 112..144 -> LEAD_SPACE.
  - LEAD_SPACE: mark rises.
    - dur 56..72 (4.5 ms) -> BIT_MARK; bit count = 0.
    - dur 24..40 (2.25 ms) -> RPT_MARK.
  - BIT_MARK: mark falls with dur 4..12 -> BIT_SPACE.
  - BIT_SPACE: mark rises.
    - dur 4..12 shifts in 0; dur 18..30 shifts in 1.
    - Shift is LSB-first into a 32-bit register; bit count +1.
    - After bit 32 -> STOP_MARK, else -> BIT_MARK.
  - STOP_MARK: mark falls with dur 4..12 -> check the frame, then IDLE.
    - Frame = byte0 addr, byte1 ~addr, byte2 cmd, byte3 ~cmd.
    - Both complements correct: addr/cmd load, valid pulses, have_frame = 1.
    - Otherwise: err pulses; addr/cmd unchanged.
  - RPT_MARK: mark falls with dur 4..12 -> IDLE.
    - rpt pulses only if have_frame = 1; otherwise no strobe and no err.
- Timeout: in any state other than IDLE, dur reaching 255 -> err pulse, go to IDLE. Covers stuck-low input and truncated frames.
- After err, FSM waits in IDLE for the next mark rising edge. A frame starting during the trailing space is accepted normally.
- Latency: valid/rpt/err rise exactly 3 clk after the ir_in transition that ends the segment (2 sync + 1 register). Each strobe lasts exactly 1 cycle.
- valid, rpt and err are mutually exclusive.
- busy goes high the cycle the FSM leaves IDLE and low the cycle it returns.
- Async rst mid-frame: everything returns to reset values immediately, including have_frame.
- A glitch shorter than 4 ticks inside a frame gives an out-of-window edge -> err.

Test Plan:
- TICK_DIV=4. Send frame addr=0x04, cmd=0x08 (bytes 04 FB 08 F7) with nominal timings -> one valid pulse 3 clk after the final ir_in rise; addr=0x04, cmd=0x08; err=rpt=0 throughout; busy low after.
- After the frame above, send a repeat code (128-tick mark, 32-tick space, 8-tick mark) -> one rpt pulse; addr/cmd still 0x04/0x08. The same repeat right after reset -> no strobe at all.
- Frame with cmd byte 0x08 and inverse byte 0xF6 -> err pulse, no valid; addr/cmd keep previous values.
- Timing edges of the window, leader mark 111 ticks -> err; leader mark 112 ticks and 144 ticks -> decode proceeds; bit space 31 ticks -> err.
- Hold ir_in low indefinitely -> err exactly when dur reaches 255 ticks; busy low afterwards.
- Assert rst during bit 17 of a frame -> all outputs 0 immediately. A subsequent full frame (addr=0x55, cmd=0xAA) -> valid, addr=0x55, cmd=0xAA.
